// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: handshaked hex/decimal multi-digit seven-segment driver with overflow and leading-zero blanking.
// Define SEG_BLINK_EN to add the blink_mask port and per-digit blinking.
module seg7_display_ctrl #(
   parameter int DIGITS    = 8,
   parameter int DATA_W    = 32
`ifdef SEG_BLINK_EN
   , parameter int BLINK_DIV = 25000000
`endif
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_dec,
   input  logic                blank_lz,
   output logic                busy,
   output logic                overflow,
`ifdef SEG_BLINK_EN
   input  logic [DIGITS-1:0]   blink_mask,
`endif
   output logic [7*DIGITS-1:0] seg_out
);
   localparam int BW = 4*DIGITS;
   localparam int CW = $clog2(DATA_W+1);
   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
   state_t              r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_data;
   logic                r_dec, r_blz, r_ovf_c;
   logic [BW-1:0]       r_bcd, w_adj, w_val;
   logic [CW-1:0]       r_cnt;
   logic [7*DIGITS-1:0] r_seg, w_seg;
   logic                w_accept, w_hex_ovf, w_ovf, w_nz;

   function automatic logic [6:0] f_enc(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;

   always_comb
      w_state_nxt = (r_state == IDLE) ? (w_accept ? (in_dec ? CONV : LOAD) : IDLE) :
                    (r_state == CONV) ? ((r_cnt == CW'(DATA_W-1)) ? LOAD : CONV) : IDLE;

   always_comb begin
      in_ready = (r_state == IDLE);
      busy     = (r_state != IDLE);
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      assign w_adj[4*g+:4] = (r_bcd[4*g+:4] >= 4'd5) ? r_bcd[4*g+:4] + 4'd3 : r_bcd[4*g+:4];
   end

   // The bit leaving the BCD MSB would belong to a digit we cannot show.
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         r_data   <= '0;
         r_dec    <= 1'b0;
         r_blz    <= 1'b0;
         r_ovf_c  <= 1'b0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_seg    <= '1;
         overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_data  <= in_data;
            r_dec   <= in_dec;
            r_blz   <= blank_lz;
            r_bcd   <= '0;
            r_ovf_c <= 1'b0;
            r_cnt   <= '0;
         end
         if (r_state == CONV) begin
            r_bcd   <= {w_adj[BW-2:0], r_data[DATA_W-1]};
            r_data  <= r_data << 1;
            r_ovf_c <= r_ovf_c | w_adj[BW-1];
            r_cnt   <= r_cnt + CW'(1);
         end
         if (r_state == LOAD) begin
            r_seg    <= w_seg;
            overflow <= w_ovf;
         end
      end

   assign w_hex_ovf = (r_data >> BW) != '0;
   assign w_val     = r_dec ? r_bcd : BW'(r_data);
   assign w_ovf     = r_dec ? r_ovf_c : w_hex_ovf;

   // Scan from the top digit; blanking stops at the first nonzero digit or at digit 0.
   always_comb begin
      w_seg = '1;
      w_nz  = 1'b0;
      for (int i = DIGITS-1; i >= 0; i--) begin
         w_nz = w_nz || (w_val[4*i+:4] != 4'd0) || (i == 0);
         w_seg[7*i+:7] = w_ovf ? 7'b0111111 : (r_blz && !w_nz) ? 7'b1111111 : f_enc(w_val[4*i+:4]);
      end
   end

`ifdef SEG_BLINK_EN
   localparam int KW = $clog2(BLINK_DIV+1);
   logic [KW-1:0]       r_bcnt;
   logic                r_phase;
   logic [7*DIGITS-1:0] w_mask;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         r_bcnt  <= '0;
         r_phase <= 1'b0;
      end else if (r_bcnt == KW'(BLINK_DIV-1)) begin
         r_bcnt  <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_bcnt  <= r_bcnt + KW'(1);
      end
   for (genvar g = 0; g < DIGITS; g++) begin : g_blink
      assign w_mask[7*g+:7] = {7{r_phase & blink_mask[g]}};
   end
   assign seg_out = r_seg | w_mask;
`else
   assign seg_out = r_seg;
`endif
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: table-driven check of hex/decimal rendering, overflow, blanking and reset behaviour.
module tb_seg7_display_ctrl;
   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        in_dec = 1'b0;
   logic        blank_lz = 1'b0;
   logic        busy;
   logic        overflow;
   logic [55:0] seg_out;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc;

   typedef struct packed {
      logic [31:0] data;
      logic        dec;
      logic        blz;
      logic        poke;
      logic [63:0] txt;
      logic        ovf;
      int          cyc;
   } vec_t;
   vec_t v [14];

   always #5 clock = ~clock;

`ifdef SEG_BLINK_EN
   logic [7:0]  blink_mask = 8'h00;
   logic [55:0] e;
   logic [6:0]  prev;
   int          run, nt;
   seg7_display_ctrl #(.DIGITS(8), .DATA_W(32), .BLINK_DIV(4)) dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dec(in_dec), .blank_lz(blank_lz), .busy(busy),
      .overflow(overflow), .blink_mask(blink_mask), .seg_out(seg_out));
`else
   seg7_display_ctrl #(.DIGITS(8), .DATA_W(32)) dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dec(in_dec), .blank_lz(blank_lz), .busy(busy),
      .overflow(overflow), .seg_out(seg_out));
`endif

   // Leftmost character is digit 7; ' ' is dark, '-' is the overflow dash.
   function automatic logic [55:0] f_txt(input logic [63:0] s);
      logic [55:0] r;
      logic [7:0]  c;
      logic [6:0]  p;
      r = '1;
      for (int i = 0; i < 8; i++) begin
         c = s[63-8*i -: 8];
         case (c)
            "0": p = 7'b1000000;
            "1": p = 7'b1111001;
            "2": p = 7'b0100100;
            "3": p = 7'b0110000;
            "4": p = 7'b0011001;
            "5": p = 7'b0010010;
            "6": p = 7'b0000010;
            "7": p = 7'b1111000;
            "8": p = 7'b0000000;
            "9": p = 7'b0010000;
            "A": p = 7'b0001000;
            "b": p = 7'b0000011;
            "C": p = 7'b1000110;
            "d": p = 7'b0100001;
            "E": p = 7'b0000110;
            "F": p = 7'b0001110;
            "-": p = 7'b0111111;
            default: p = 7'b1111111;
         endcase
         r[7*(7-i) +: 7] = p;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic dec, input logic blz, input logic poke, output int c);
      int t;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clock);
         t++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: in_ready never rose");
      end
      in_valid = 1'b1;
      in_data  = d;
      in_dec   = dec;
      blank_lz = blz;
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = 32'h0BAD_F00D;
      in_dec   = ~dec;
      blank_lz = ~blz;
      c = 0;
      while (busy && c < 200) begin
         c++;
         in_valid = poke && c < 10;
         in_data  = 32'h7;
         @(negedge clock);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      v[0]  = '{32'h000000A5, 1'b0, 1'b1, 1'b0, "      A5", 1'b0, 1};
      v[1]  = '{32'h000000A5, 1'b0, 1'b0, 1'b0, "000000A5", 1'b0, 1};
      v[2]  = '{32'hDEADBEEF, 1'b0, 1'b0, 1'b0, "dEAdbEEF", 1'b0, 1};
      v[3]  = '{32'h01234567, 1'b0, 1'b1, 1'b0, " 1234567", 1'b0, 1};
      v[4]  = '{32'h00000000, 1'b0, 1'b1, 1'b0, "       0", 1'b0, 1};
      v[5]  = '{32'h89ABCDEF, 1'b0, 1'b1, 1'b0, "89AbCdEF", 1'b0, 1};
      v[6]  = '{32'd12345678, 1'b1, 1'b0, 1'b1, "12345678", 1'b0, 33};
      v[7]  = '{32'd100000000, 1'b1, 1'b0, 1'b0, "--------", 1'b1, 33};
      v[8]  = '{32'd0,        1'b1, 1'b1, 1'b0, "       0", 1'b0, 33};
      v[9]  = '{32'd99999999, 1'b1, 1'b0, 1'b0, "99999999", 1'b0, 33};
      v[10] = '{32'd42,       1'b1, 1'b1, 1'b0, "      42", 1'b0, 33};
      v[11] = '{32'd1000,     1'b1, 1'b1, 1'b0, "    1000", 1'b0, 33};
      v[12] = '{32'd10000000, 1'b1, 1'b1, 1'b0, "10000000", 1'b0, 33};
      v[13] = '{32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, "--------", 1'b1, 33};

      repeat (2) @(negedge clock);
      chk("rst_seg", seg_out, {56{1'b1}});
      chk("rst_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      resetn = 1'b1;
      @(negedge clock);

      for (int k = 0; k < 14; k++) begin
         send(v[k].data, v[k].dec, v[k].blz, v[k].poke, cyc);
         chk($sformatf("v%0d_seg", k), seg_out, f_txt(v[k].txt));
         chk($sformatf("v%0d_ovf", k), overflow, v[k].ovf);
         chk($sformatf("v%0d_busy_cycles", k), cyc, v[k].cyc);
         chk($sformatf("v%0d_ready", k), in_ready, 1);
      end

      repeat (20) @(negedge clock);
      chk("hold_seg", seg_out, f_txt("--------"));
      chk("hold_ovf", overflow, 1);

      // Abort a conversion about ten cycles in.
      in_valid = 1'b1;
      in_data  = 32'd87654321;
      in_dec   = 1'b1;
      blank_lz = 1'b0;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (9) @(negedge clock);
      chk("midconv_busy", busy, 1);
      resetn = 1'b0;
      #1;
      chk("midrst_seg", seg_out, {56{1'b1}});
      chk("midrst_ready", in_ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_ovf", overflow, 0);
      @(negedge clock);
      resetn = 1'b1;
      repeat (40) @(negedge clock);
      chk("postrst_seg", seg_out, {56{1'b1}});
      send(32'd42, 1'b1, 1'b1, 1'b0, cyc);
      chk("postrst42_seg", seg_out, f_txt("      42"));
      chk("postrst42_busy_cycles", cyc, 33);

`ifdef SEG_BLINK_EN
      blink_mask = 8'h01;
      send(32'h5, 1'b0, 1'b0, 1'b0, cyc);
      e = f_txt("00000005");
      prev = seg_out[6:0];
      run = 1;
      nt = 0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clock);
         chk("blink_steady", seg_out[55:7], e[55:7]);
         if (seg_out[6:0] !== e[6:0]) chk("blink_dark", seg_out[6:0], 7'h7F);
         if (seg_out[6:0] !== prev) begin
            if (nt > 0) chk("blink_period", run, 4);
            nt++;
            run = 1;
            prev = seg_out[6:0];
         end else begin
            run++;
         end
      end
      chk("blink_toggled", nt >= 4, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
